// File: rtl/bus_arbiter_rr_nm1s.sv
// rtl/bus_arbiter_rr_nm1s.sv - N-master round-robin arbiter with window decode and in-order response routing
module bus_arbiter_rr_nm1s #(
    parameter int          NUM_MASTERS     = 2,
    parameter logic [31:0] SLAVE_START     = 32'h0,
    parameter logic [31:0] SLAVE_SIZE      = 32'h8000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_MASTERS-1:0]    m_req_i,
    input  logic [NUM_MASTERS*32-1:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS*4-1:0]  m_be_i,
    input  logic [NUM_MASTERS*32-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]    m_gnt_o,
    output logic [NUM_MASTERS-1:0]    m_rvalid_o,
    output logic [NUM_MASTERS*32-1:0] m_rdata_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic                      s_req_o,
    output logic [31:0]               s_addr_o,
    output logic                      s_we_o,
    output logic [3:0]                s_be_o,
    output logic [31:0]               s_wdata_o,
    input  logic                      s_gnt_i,
    input  logic                      s_rvalid_i,
    input  logic [31:0]               s_rdata_i,
    input  logic                      s_err_i,
    output logic                      busy_o,
    output logic                      proto_err_o
);
    localparam int          IW   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int          PW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int          CW   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] MASK = ~(SLAVE_SIZE - 32'd1);

    logic [IW-1:0] ptr_q, ptr_d, sel_q, sel_d, sel, head;
    logic          lock_q, lock_d, proto_q, proto_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] fifo_q [MAX_OUTSTANDING];

    logic [NUM_MASTERS-1:0] elig;
    logic found, blocked, req_go, accept, pop, empty;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            elig[i] = m_req_i[i] && ((m_addr_i[32*i +: 32] & MASK) == SLAVE_START);
        end
    end

    // A locked master keeps the slave channel regardless of newer eligible requests.
    always_comb begin
        found = 1'b0;
        sel   = sel_q;
        if (lock_q) begin
            found = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                if (!found && elig[(int'(ptr_q) + k) % NUM_MASTERS]) begin
                    found = 1'b1;
                    sel   = IW'((int'(ptr_q) + k) % NUM_MASTERS);
                end
            end
        end
    end

    assign empty   = (cnt_q == '0);
    assign blocked = (cnt_q == CW'(MAX_OUTSTANDING));
    assign req_go  = found && !blocked && !rst_i;
    assign accept  = req_go && s_gnt_i;
    assign pop     = s_rvalid_i && !empty && !rst_i;
    assign head    = fifo_q[rd_q];

    always_comb begin
        s_req_o   = req_go;
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        m_gnt_o   = '0;
        if (req_go) begin
            s_addr_o  = m_addr_i[32*int'(sel) +: 32];
            s_we_o    = m_we_i[sel];
            s_be_o    = m_be_i[4*int'(sel) +: 4];
            s_wdata_o = m_wdata_i[32*int'(sel) +: 32];
            m_gnt_o[sel] = s_gnt_i;
        end
    end

    always_comb begin
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        m_err_o    = '0;
        if (pop) begin
            m_rvalid_o[head]                 = 1'b1;
            m_rdata_o[32*int'(head) +: 32]   = s_rdata_i;
            m_err_o[head]                    = s_err_i;
        end
    end

    assign busy_o      = !empty && !rst_i;
    assign proto_err_o = proto_q;

    always_comb begin
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        lock_d  = lock_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        proto_d = proto_q | (s_rvalid_i & empty);
        if (accept) begin
            ptr_d  = sel;
            lock_d = 1'b0;
            wr_d   = (wr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_q + PW'(1);
        end else if (req_go) begin
            lock_d = 1'b1;
            sel_d  = sel;
        end
        if (pop) begin
            rd_d = (rd_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_q + PW'(1);
        end
        if (accept && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!accept && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q   <= IW'(NUM_MASTERS - 1);
            sel_q   <= '0;
            lock_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            proto_q <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            lock_q  <= lock_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            proto_q <= proto_d;
            if (accept) begin
                fifo_q[wr_q] <= sel;
            end
        end
    end
endmodule

// File: tb/tb_bus_arbiter_rr_nm1s.sv
// tb/tb_bus_arbiter_rr_nm1s.sv - directed self-checking bench for bus_arbiter_rr_nm1s
module tb_bus_arbiter_rr_nm1s;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req, m_we, m_gnt, m_rvalid, m_err;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [7:0]  m_be;
    logic        s_req, s_we, s_gnt, s_rvalid, s_err, busy, proto_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    bus_arbiter_rr_nm1s #(
        .NUM_MASTERS(2), .SLAVE_START(32'h0), .SLAVE_SIZE(32'h8000), .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
        .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .m_err_o(m_err),
        .s_req_o(s_req), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
        .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_err_i(s_err),
        .busy_o(busy), .proto_err_o(proto_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_err = 1'b0;
        #1;
        check_eq("rst_sreq", s_req, 0);
        check_eq("rst_busy", busy, 0);
        next_cycle();
        rst = 1'b0;
        #1;
        check_eq("rst_proto", proto_err, 0);
        check_eq("rst_gnt", m_gnt, 0);

        // 1: alternating grants and in-order routing
        next_cycle();
        m_req = 2'b11; m_addr = {32'h104, 32'h100}; m_we = 2'b10; m_be = 8'hF3;
        m_wdata = {32'h2222_0000, 32'h1111_0000}; s_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_rvalid = (k > 0);
            s_rdata  = 32'hA0 + k;
            #1;
            check_eq("t1_gnt", m_gnt, (k % 2) ? 2'b10 : 2'b01);
            check_eq("t1_saddr", s_addr, (k % 2) ? 32'h104 : 32'h100);
            check_eq("t1_swe", s_we, (k % 2) ? 1 : 0);
            check_eq("t1_sbe", s_be, (k % 2) ? 4'hF : 4'h3);
            if (k > 0) begin
                check_eq("t1_rvalid", m_rvalid, ((k - 1) % 2) ? 2'b10 : 2'b01);
                check_eq("t1_rdata", m_rdata,
                         ((k - 1) % 2) ? {32'hA0 + k, 32'h0} : {32'h0, 32'hA0 + k});
            end
            next_cycle();
        end
        m_req = 2'b00; s_rvalid = 1'b1; s_rdata = 32'h55; s_err = 1'b1;
        #1;
        check_eq("t1_last_rvalid", m_rvalid, 2'b10);
        check_eq("t1_last_err", m_err, 2'b10);
        next_cycle();
        s_rvalid = 1'b0; s_err = 1'b0;
        #1;
        check_eq("t1_busy_drained", busy, 0);

        // 2: address outside window is never granted
        m_req = 2'b10; m_addr = {32'h8000, 32'h0};
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("t2_sreq", s_req, 0);
            check_eq("t2_gnt", m_gnt, 0);
            next_cycle();
        end

        // 3: lock holds M0 through stalled grant
        m_req = 2'b01; m_addr = {32'h300, 32'h200}; s_gnt = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 2) m_req = 2'b11;
            #1;
            check_eq("t3_lock_saddr", s_addr, 32'h200);
            check_eq("t3_lock_gnt", m_gnt, 0);
            next_cycle();
        end
        s_gnt = 1'b1;
        #1;
        check_eq("t3_gnt_m0", m_gnt, 2'b01);
        check_eq("t3_saddr4", s_addr, 32'h200);
        next_cycle();
        s_rvalid = 1'b1; s_rdata = 32'h77;
        #1;
        check_eq("t3_gnt_m1", m_gnt, 2'b10);
        check_eq("t3_saddr5", s_addr, 32'h300);
        check_eq("t3_rvalid_m0", m_rvalid, 2'b01);
        next_cycle();
        m_req = 2'b00;
        #1;
        check_eq("t3_rvalid_m1", m_rvalid, 2'b10);
        next_cycle();
        s_rvalid = 1'b0;

        // 4: blocking at MAX_OUTSTANDING
        m_req = 2'b11; m_addr = {32'h10, 32'h20};
        #1;
        check_eq("t4_acc1", m_gnt, 2'b01);
        next_cycle();
        #1;
        check_eq("t4_acc2", m_gnt, 2'b10);
        next_cycle();
        #1;
        check_eq("t4_blk_sreq", s_req, 0);
        check_eq("t4_blk_gnt", m_gnt, 0);
        next_cycle();
        s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF;
        #1;
        check_eq("t4_pop_sreq", s_req, 0);
        check_eq("t4_rvalid", m_rvalid, 2'b01);
        check_eq("t4_rdata", m_rdata, {32'h0, 32'hDEADBEEF});
        next_cycle();
        s_rvalid = 1'b0;
        #1;
        check_eq("t4_resume_sreq", s_req, 1);
        check_eq("t4_resume_gnt", m_gnt, 2'b01);
        next_cycle();
        m_req = 2'b00; s_rvalid = 1'b1;
        #1;
        check_eq("t4_drain1", m_rvalid, 2'b10);
        next_cycle();
        #1;
        check_eq("t4_drain2", m_rvalid, 2'b01);
        next_cycle();

        // 5: response with nothing outstanding
        #1;
        check_eq("t5_no_rvalid", m_rvalid, 0);
        check_eq("t5_proto_pre", proto_err, 0);
        next_cycle();
        s_rvalid = 1'b0;
        #1;
        check_eq("t5_proto_set", proto_err, 1);
        next_cycle();
        #1;
        check_eq("t5_proto_sticky", proto_err, 1);

        // 6: reset with a transaction outstanding
        m_req = 2'b10;
        #1;
        check_eq("t6_acc_m1", m_gnt, 2'b10);
        next_cycle();
        #1;
        check_eq("t6_busy", busy, 1);
        m_req = 2'b11; rst = 1'b1;
        #1;
        check_eq("t6_rst_sreq", s_req, 0);
        check_eq("t6_rst_gnt", m_gnt, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_proto", proto_err, 0);
        next_cycle();
        rst = 1'b0;
        #1;
        check_eq("t6_tie_m0", m_gnt, 2'b01);
        check_eq("t6_sreq", s_req, 1);
        next_cycle();
        m_req = 2'b00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
